// File: rtl/rd_data2b.sv
// rd_data2b: fetches one 128-bit block for the AES core.
//
// On a start pulse in IDLE, four pipelined 32-bit reads are issued to data
// memory at BASE_ADDR, BASE_ADDR+ADDR_STEP, ... The returned words are packed
// into block_out, lowest address in the most significant word. The block is
// then offered to the AES core with a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        fetch request, sampled only in IDLE
//   en_r_datamem data-memory read enable
//   addr_rd      data-memory read address (byte address)
//   data_rd      data-memory read data, valid the cycle after the address is sampled
//   block_out    assembled 128-bit block
//   block_valid  block_out holds a complete block
//   block_ready  AES core accepts the block
//   busy         high in every state except IDLE
//
// Build option:
//   RD_DATA2B_BYTESWAP_EN  byte-reverse every word at capture. This converts
//                          little-endian memory words to AES byte order.
//                          Timing is unchanged.

module rd_data2b #(
    parameter logic [31:0] BASE_ADDR = 32'd400,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    output logic         en_r_datamem,
    output logic [31:0]  addr_rd,
    input  logic [31:0]  data_rd,
    output logic [127:0] block_out,
    output logic         block_valid,
    input  logic         block_ready,
    output logic         busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;      // index of the address currently driven
    logic              cap_v;    // a read was sampled by memory at the last edge
    logic [IDX_W-1:0]  cap_idx;  // which word that read returns

    // Word formatting applied at capture
    function automatic logic [DATA_W-1:0] fmt_word(input logic [DATA_W-1:0] w);
`ifdef RD_DATA2B_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Issue/capture control, registered outputs.
    // Read k drives its address after edge Ek. The memory samples it at Ek+1,
    // and the word is captured at Ek+2. Together, the enable/index registers
    // and cap_v/cap_idx form the two-deep tracking pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            idx          <= '0;
            cap_v        <= 1'b0;
            cap_idx      <= '0;
            en_r_datamem <= 1'b0;
            addr_rd      <= '0;
            block_out    <= '0;
            block_valid  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            cap_v   <= en_r_datamem;
            cap_idx <= idx;

            // Pack: word 0 into the top 32 bits, word 3 into the bottom
            if (cap_v) begin
                case (cap_idx)
                    2'd0:    block_out[127:96] <= fmt_word(data_rd);
                    2'd1:    block_out[95:64]  <= fmt_word(data_rd);
                    2'd2:    block_out[63:32]  <= fmt_word(data_rd);
                    default: block_out[31:0]   <= fmt_word(data_rd);
                endcase
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= READ;
                        en_r_datamem <= 1'b1;
                        addr_rd      <= BASE_ADDR;
                        idx          <= '0;
                        busy         <= 1'b1;
                    end
                end
                READ: begin
                    // The last address has been driven for one cycle, so stop issuing
                    if (idx == LAST_IDX) begin
                        en_r_datamem <= 1'b0;
                        state        <= DRAIN;
                    end else begin
                        idx     <= idx + IDX_W'(1);
                        addr_rd <= addr_rd + ADDR_STEP;  // wraps modulo 2^32
                    end
                end
                DRAIN: begin
                    if (cap_v && (cap_idx == LAST_IDX)) begin
                        block_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (block_ready) begin
                        block_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rd_data2b.sv
// Directed self-checking bench for rd_data2b.
module tb_rd_data2b;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start, start2;
    logic         block_ready, block_ready2;
    logic         en_r_datamem, en2;
    logic [31:0]  addr_rd, addr2;
    logic [31:0]  data_rd = '0;
    logic [31:0]  data2 = '0;
    logic [127:0] block_out, block2;
    logic         block_valid, valid2;
    logic         busy, busy2;

    int checks = 0;
    int failures = 0;
    int rd_cnt = 0;
    int hs_cnt = 0;
    int rd_snap, hs_snap;

`ifdef RD_DATA2B_BYTESWAP_EN
    localparam logic [127:0] EXP_BLK  = 128'h33221100_77665544_BBAA9988_FFEEDDCC;
    localparam logic [127:0] EXP_WRAP = 128'hEFBEADDE_67452301_EFCDAB89_0DF0FECA;
`else
    localparam logic [127:0] EXP_BLK  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] EXP_WRAP = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
`endif

    rd_data2b dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .en_r_datamem(en_r_datamem), .addr_rd(addr_rd), .data_rd(data_rd),
        .block_out(block_out), .block_valid(block_valid),
        .block_ready(block_ready), .busy(busy)
    );

    rd_data2b #(.BASE_ADDR(32'hFFFF_FFF8), .ADDR_STEP(32'd4)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .start(start2),
        .en_r_datamem(en2), .addr_rd(addr2), .data_rd(data2),
        .block_out(block2), .block_valid(valid2),
        .block_ready(block_ready2), .busy(busy2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd400:        return 32'h0011_2233;
            32'd404:        return 32'h4455_6677;
            32'd408:        return 32'h8899_AABB;
            32'd412:        return 32'hCCDD_EEFF;
            32'hFFFF_FFF8:  return 32'hDEAD_BEEF;
            32'hFFFF_FFFC:  return 32'h0123_4567;
            32'h0000_0000:  return 32'h89AB_CDEF;
            32'h0000_0004:  return 32'hCAFE_F00D;
            default:        return 32'hBAD0_BAD0;
        endcase
    endfunction

    // Synchronous memories, one per instance
    always @(posedge clk) if (en_r_datamem) data_rd <= mem_word(addr_rd);
    always @(posedge clk) if (en2) data2 <= mem_word(addr2);

    // Count issued reads and completed handshakes of the main instance
    always @(posedge clk) begin
        if (en_r_datamem) rd_cnt <= rd_cnt + 1;
        if (block_valid && block_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; start2 = 1'b0;
        block_ready = 1'b1; block_ready2 = 1'b1;
        repeat (3) tick();
        chk("rst_en", 128'(en_r_datamem), 128'(0));
        chk("rst_addr", 128'(addr_rd), 128'(0));
        chk("rst_blk", block_out, 128'(0));
        chk("rst_valid", 128'(block_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        reset_n = 1'b1;
        tick();

        // Basic fetch with block_ready already high
        start = 1'b1;
        tick();                                    // E0
        start = 1'b0;
        rd_snap = rd_cnt; hs_snap = hs_cnt;
        chk("e0_en", 128'(en_r_datamem), 128'(1));
        chk("e0_addr", 128'(addr_rd), 128'(400));
        chk("e0_busy", 128'(busy), 128'(1));
        chk("e0_valid", 128'(block_valid), 128'(0));
        tick(); chk("e1_addr", 128'(addr_rd), 128'(404));
        tick(); chk("e2_addr", 128'(addr_rd), 128'(408));
        tick(); chk("e3_addr", 128'(addr_rd), 128'(412));
        chk("e3_en", 128'(en_r_datamem), 128'(1));
        tick(); chk("e4_en", 128'(en_r_datamem), 128'(0));
        chk("e4_valid", 128'(block_valid), 128'(0));
        tick(); chk("e5_valid", 128'(block_valid), 128'(1));
        chk("e5_blk", block_out, EXP_BLK);
        chk("e5_busy", 128'(busy), 128'(1));
        tick(); chk("e6_valid", 128'(block_valid), 128'(0));
        chk("e6_busy", 128'(busy), 128'(0));
        chk("t1_reads", 128'(rd_cnt - rd_snap), 128'(4));
        chk("t1_hs", 128'(hs_cnt - hs_snap), 128'(1));

        // Back-to-back start, block_ready low, start pulses during READ and HOLD
        start = 1'b1; block_ready = 1'b0;
        tick();                                    // E7 = F0
        chk("f0_en", 128'(en_r_datamem), 128'(1));
        chk("f0_addr", 128'(addr_rd), 128'(400));
        start = 1'b0;
        rd_snap = rd_cnt; hs_snap = hs_cnt;
        tick(); start = 1'b1;                      // F1
        tick(); start = 1'b0;                      // F2
        chk("f2_addr", 128'(addr_rd), 128'(408));
        tick(); tick();                            // F4
        chk("f4_en", 128'(en_r_datamem), 128'(0));
        tick();                                    // F5
        chk("f5_valid", 128'(block_valid), 128'(1));
        chk("f5_blk", block_out, EXP_BLK);
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", 128'(block_valid), 128'(1));
            chk("hold_blk", block_out, EXP_BLK);
        end
        start = 1'b0; block_ready = 1'b1;
        tick();
        chk("rel_valid", 128'(block_valid), 128'(0));
        chk("rel_busy", 128'(busy), 128'(0));
        repeat (3) tick();
        chk("t2_idle_en", 128'(en_r_datamem), 128'(0));
        chk("t2_idle_busy", 128'(busy), 128'(0));
        chk("t2_reads", 128'(rd_cnt - rd_snap), 128'(4));
        chk("t2_hs", 128'(hs_cnt - hs_snap), 128'(1));
        chk("t2_blk_kept", block_out, EXP_BLK);

        // Asynchronous reset after the second read
        start = 1'b1;
        tick(); start = 1'b0;                      // G0
        tick();                                    // G1
        chk("g1_addr", 128'(addr_rd), 128'(404));
        tick();                                    // G2
        #2 reset_n = 1'b0;
        #1;
        chk("arst_en", 128'(en_r_datamem), 128'(0));
        chk("arst_addr", 128'(addr_rd), 128'(0));
        chk("arst_blk", block_out, 128'(0));
        chk("arst_valid", 128'(block_valid), 128'(0));
        chk("arst_busy", 128'(busy), 128'(0));
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_blk", block_out, 128'(0));
        chk("post_rst_busy", 128'(busy), 128'(0));
        start = 1'b1;
        tick(); start = 1'b0;                      // H0
        chk("h0_addr", 128'(addr_rd), 128'(400));
        repeat (4) tick();
        tick();                                    // H5
        chk("h5_valid", 128'(block_valid), 128'(1));
        chk("h5_blk", block_out, EXP_BLK);
        tick();
        chk("h6_valid", 128'(block_valid), 128'(0));

        // Address wrap at 2^32
        start2 = 1'b1;
        tick(); start2 = 1'b0;
        chk("w0_addr", 128'(addr2), 128'(32'hFFFF_FFF8));
        chk("w0_en", 128'(en2), 128'(1));
        tick(); chk("w1_addr", 128'(addr2), 128'(32'hFFFF_FFFC));
        tick(); chk("w2_addr", 128'(addr2), 128'(32'h0000_0000));
        tick(); chk("w3_addr", 128'(addr2), 128'(32'h0000_0004));
        tick(); chk("w4_en", 128'(en2), 128'(0));
        tick(); chk("w5_valid", 128'(valid2), 128'(1));
        chk("w5_blk", block2, EXP_WRAP);
        tick(); chk("w6_valid", 128'(valid2), 128'(0));
        chk("w6_busy", 128'(busy2), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
